mreq_arbiter: RTL

- Shares one downstream MREQ command port among N upstream requesters (DMA engines, register-access bridges).
- The downstream port feeds the command serializer that frames START/OP/WCOUNT/ADDR/CRC bytes.
- Selects one requester by round-robin or fixed priority and captures its request fields.
- Holds that grant until the downstream completion pulse, then routes the pulse back to the winner.

---
 rtl/mreq_arbiter_pkg.sv | 26 ++
 rtl/mreq_arbiter_if.sv | 43 ++++
 rtl/mreq_arbiter_rr_pick.sv | 40 ++++
 rtl/mreq_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/mreq_arbiter_pkg.sv
// Shared MREQ command-path definitions: serializer framing constants, MREQ field
// widths, and the arbiter state/command types.
package mreq_arbiter_pkg;

  localparam logic [7:0] CMD_TX_START = 8'hA5;
  localparam logic [7:0] CMD_OP_READ  = 8'h01;
  localparam logic [7:0] CMD_OP_WRITE = 8'h02;

  localparam int MREQ_WSIZE_W = 2;
  localparam int MREQ_SIZE_W  = 8;
  localparam int MREQ_ADDR_W  = 32;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } arb_state_e;

  typedef struct packed {
    logic                    wr;
    logic [MREQ_WSIZE_W-1:0] wsize;
    logic                    aincr;
    logic [MREQ_SIZE_W-1:0]  size;
    logic [MREQ_ADDR_W-1:0]  addr;
  } mreq_cmd_t;

endpackage

// File: rtl/mreq_arbiter_if.sv
// Bundle of the N upstream MREQ request ports, the shared downstream port and
// the arbiter status outputs.
interface mreq_arbiter_if #(
  parameter int N = 4
);
  import mreq_arbiter_pkg::*;

  logic                      i_prio_mode;
  logic [N-1:0]              i_req_valid;
  logic [N-1:0]              o_req_ready;
  logic [N-1:0]              i_req_wr;
  logic [MREQ_WSIZE_W*N-1:0] i_req_wsize;
  logic [N-1:0]              i_req_aincr;
  logic [MREQ_SIZE_W*N-1:0]  i_req_size;
  logic [MREQ_ADDR_W*N-1:0]  i_req_addr;

  logic                      o_mreq_valid;
  logic                      i_mreq_ready;
  logic                      o_mreq_wr;
  logic [MREQ_WSIZE_W-1:0]   o_mreq_wsize;
  logic                      o_mreq_aincr;
  logic [MREQ_SIZE_W-1:0]    o_mreq_size;
  logic [MREQ_ADDR_W-1:0]    o_mreq_addr;

  logic [N-1:0]              o_grant;
  logic                      o_proto_err;

  // Environment side: requesters plus the downstream serializer.
  modport master (
    output i_prio_mode, i_req_valid, i_req_wr, i_req_wsize, i_req_aincr,
           i_req_size, i_req_addr, i_mreq_ready,
    input  o_req_ready, o_mreq_valid, o_mreq_wr, o_mreq_wsize, o_mreq_aincr,
           o_mreq_size, o_mreq_addr, o_grant, o_proto_err
  );

  modport slave (
    input  i_prio_mode, i_req_valid, i_req_wr, i_req_wsize, i_req_aincr,
           i_req_size, i_req_addr, i_mreq_ready,
    output o_req_ready, o_mreq_valid, o_mreq_wr, o_mreq_wsize, o_mreq_aincr,
           o_mreq_size, o_mreq_addr, o_grant, o_proto_err
  );

endinterface

// File: rtl/mreq_arbiter_rr_pick.sv
// Combinational winner selection: round-robin starting after the last grant,
// or fixed priority with the lowest index winning.
module mreq_arbiter_rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] last_i,
  input  logic            mode_i,
  output logic [IDXW-1:0] win_o,
  output logic            any_o
);

  logic found;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path leaves a value held (no latch).
  always_comb begin
    win_o = '0;
    found = 1'b0;
    any_o = |req_i;
    if (mode_i) begin
      for (int i = 0; i < N; i++) begin
        if (req_i[i] && !found) begin
          win_o = IDXW'(i);
          found = 1'b1;
        end
      end
    end else begin
      // Offsets 1..N visit last+1 first and last itself at the end.
      for (int off = 1; off <= N; off++) begin
        if (req_i[(int'(last_i) + off) % N] && !found) begin
          win_o = IDXW'((int'(last_i) + off) % N);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mreq_arbiter.sv
// Shares one downstream MREQ command port among N requesters; holds each grant
// until the downstream completion pulse and routes that pulse back to the winner.
module mreq_arbiter
  import mreq_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input logic          clk,
  input logic          rst,
  mreq_arbiter_if.slave bus
);

  localparam int IDXW = $clog2(N);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] grant_q, grant_d;
  logic [IDXW-1:0] last_q, last_d;
  mreq_cmd_t       cmd_q, cmd_d;
  logic            err_q, err_d;

  logic [IDXW-1:0] win;
  logic            any_req;
  mreq_cmd_t       sel_cmd;
  logic [N-1:0]    grant_oh;
  logic            busy;

  mreq_arbiter_rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .req_i  (bus.i_req_valid),
    .last_i (last_q),
    .mode_i (bus.i_prio_mode),
    .win_o  (win),
    .any_o  (any_req)
  );

  always_comb begin
    sel_cmd.wr    = bus.i_req_wr[win];
    sel_cmd.wsize = bus.i_req_wsize[int'(win)*MREQ_WSIZE_W +: MREQ_WSIZE_W];
    sel_cmd.aincr = bus.i_req_aincr[win];
    sel_cmd.size  = bus.i_req_size[int'(win)*MREQ_SIZE_W +: MREQ_SIZE_W];
    sel_cmd.addr  = bus.i_req_addr[int'(win)*MREQ_ADDR_W +: MREQ_ADDR_W];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cmd_d   = cmd_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = win;
          cmd_d   = sel_cmd;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!bus.i_req_valid[grant_q] && !bus.i_mreq_ready) err_d = 1'b1;
        if (bus.i_mreq_ready) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDXW'(N - 1);
      cmd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
    end
  end

  assign busy     = (state_q == ST_BUSY);
  assign grant_oh = {{(N-1){1'b0}}, 1'b1} << grant_q;

  // A transaction being abandoned by reset never sees its completion pulse.
  assign bus.o_req_ready  = (busy && bus.i_mreq_ready && !rst) ? grant_oh : '0;
  assign bus.o_grant      = busy ? grant_oh : '0;
  assign bus.o_mreq_valid = busy;
  assign bus.o_mreq_wr    = cmd_q.wr;
  assign bus.o_mreq_wsize = cmd_q.wsize;
  assign bus.o_mreq_aincr = cmd_q.aincr;
  assign bus.o_mreq_size  = cmd_q.size;
  assign bus.o_mreq_addr  = cmd_q.addr;
  assign bus.o_proto_err  = err_q;

endmodule
